ps2_key_decoder: RTL and testbench

Consumes raw scan-code bytes from the PS/2 receiver FIFO through its `ready`/`nextdata_n` pop handshake. Each byte is popped exactly once. The block resolves the E0, F0 and E1 prefixes into make/break key events and tracks the Shift, Ctrl and Caps Lock state. It presents one event at a time, with a translated ASCII code, on a valid/ready output toward the display and console logic.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_key_decoder_ascii_map.sv | 85 ++++++++
 rtl/ps2_key_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key decoder.
//   - Scan-code constants (scan code set 2) for prefixes and modifier keys.
//   - FSM state encoding.
//   - The key event record presented on the ev_* outputs.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bytes following E1 in the Pause make/break sequence.
    localparam logic [2:0] SKIP_PAUSE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_SETTLE,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] ascii;
    } key_event_t;

endpackage

// File: rtl/ps2_key_decoder_ascii_map.sv
// ps2_ascii_map: combinational scan code (set 2) to ASCII translation.
//   code  in  8  scan code with prefixes stripped
//   ext   in  1  key was E0-prefixed (all such keys map to 0)
//   shift in  1  shift state before the current event
//   caps  in  1  caps lock state before the current event
//   ascii out 8  translated character, 0 when unmapped
module ps2_ascii_map (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] lower;     // lowercase letter, 0 if not a letter key
    logic [7:0] digit;     // unshifted digit, 0 if not a digit key
    logic [7:0] digit_sh;  // shifted symbol on the digit row

    always_comb begin
        lower    = 8'h00;
        digit    = 8'h00;
        digit_sh = 8'h00;
        case (code)
            8'h1C: lower = 8'h61;  // a
            8'h32: lower = 8'h62;  // b
            8'h21: lower = 8'h63;  // c
            8'h23: lower = 8'h64;  // d
            8'h24: lower = 8'h65;  // e
            8'h2B: lower = 8'h66;  // f
            8'h34: lower = 8'h67;  // g
            8'h33: lower = 8'h68;  // h
            8'h43: lower = 8'h69;  // i
            8'h3B: lower = 8'h6A;  // j
            8'h42: lower = 8'h6B;  // k
            8'h4B: lower = 8'h6C;  // l
            8'h3A: lower = 8'h6D;  // m
            8'h31: lower = 8'h6E;  // n
            8'h44: lower = 8'h6F;  // o
            8'h4D: lower = 8'h70;  // p
            8'h15: lower = 8'h71;  // q
            8'h2D: lower = 8'h72;  // r
            8'h1B: lower = 8'h73;  // s
            8'h2C: lower = 8'h74;  // t
            8'h3C: lower = 8'h75;  // u
            8'h2A: lower = 8'h76;  // v
            8'h1D: lower = 8'h77;  // w
            8'h22: lower = 8'h78;  // x
            8'h35: lower = 8'h79;  // y
            8'h1A: lower = 8'h7A;  // z
            8'h16: begin digit = 8'h31; digit_sh = 8'h21; end  // 1 !
            8'h1E: begin digit = 8'h32; digit_sh = 8'h40; end  // 2 @
            8'h26: begin digit = 8'h33; digit_sh = 8'h23; end  // 3 #
            8'h25: begin digit = 8'h34; digit_sh = 8'h24; end  // 4 $
            8'h2E: begin digit = 8'h35; digit_sh = 8'h25; end  // 5 %
            8'h36: begin digit = 8'h36; digit_sh = 8'h5E; end  // 6 ^
            8'h3D: begin digit = 8'h37; digit_sh = 8'h26; end  // 7 &
            8'h3E: begin digit = 8'h38; digit_sh = 8'h2A; end  // 8 *
            8'h46: begin digit = 8'h39; digit_sh = 8'h28; end  // 9 (
            8'h45: begin digit = 8'h30; digit_sh = 8'h29; end  // 0 )
            default: ;
        endcase
    end

    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            if (lower != 8'h00) begin
                // Caps Lock only affects letters; shift cancels it.
                ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
            end else if (digit != 8'h00) begin
                ascii = shift ? digit_sh : digit;
            end else begin
                case (code)
                    8'h29:   ascii = 8'h20;  // space
                    8'h5A:   ascii = 8'h0D;  // enter
                    8'h66:   ascii = 8'h08;  // backspace
                    8'h0D:   ascii = 8'h09;  // tab
                    8'h76:   ascii = 8'h1B;  // escape
                    default: ascii = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops scan-code bytes from the PS/2 receiver FIFO, resolves
// E0/F0/E1 prefixes into make/break events, tracks Shift/Ctrl/Caps Lock and
// presents one event at a time with its ASCII translation.
//   clk, clrn            clock, asynchronous active-low reset
//   ready, data          receiver FIFO non-empty flag and head byte
//   overflow             receiver FIFO overflow flag
//   nextdata_n           active-low one-cycle pop request
//   ev_valid, ev_ready   event handshake toward the consumer
//   ev_code/ext/break/repeat/ascii   event payload, held while ev_valid
//   shift, ctrl, caps    current modifier state
//   key_count            distinct (non-repeat) presses, wraps at 256
//   lost                 sticky overflow indication
// SETTLE_CYC (>= 1) is the number of cycles ready is ignored after a pop.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic [7:0] ev_ascii,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic [7:0] key_count,
    output logic       lost
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_p_q, ext_p_d;
    logic       brk_p_q, brk_p_d;
    logic [2:0] skip_q, skip_d;
    logic [7:0] last_key_q, last_key_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       ev_valid_q, ev_valid_d;
    key_event_t ev_q, ev_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d;
    logic       rctrl_q, rctrl_d;
    logic       shift_q, shift_d;
    logic       ctrl_q, ctrl_d;
    logic       caps_q, caps_d;
    logic [7:0] key_count_q, key_count_d;
    logic       lost_q, lost_d;

    logic       is_make;
    logic       is_rpt;
    logic [7:0] ascii_w;

    // Translation uses the modifier state as it stood before this byte.
    ps2_ascii_map u_ascii_map (
        .code  (byte_q),
        .ext   (ext_p_q),
        .shift (shift_q),
        .caps  (caps_q),
        .ascii (ascii_w)
    );

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        byte_d       = byte_q;
        ext_p_d      = ext_p_q;
        brk_p_d      = brk_p_q;
        skip_d       = skip_q;
        last_key_d   = last_key_q;
        nextdata_n_d = 1'b1;
        ev_valid_d   = ev_valid_q;
        ev_d         = ev_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        lctrl_d      = lctrl_q;
        rctrl_d      = rctrl_q;
        caps_d       = caps_q;
        key_count_d  = key_count_q;
        lost_d       = lost_q;
        is_make      = !brk_p_q;
        is_rpt       = !brk_p_q && (byte_q == last_key_q);

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = ST_POP;
                end
            end

            ST_POP: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_q != CNT_W'(SETTLE_CYC - 1)) begin
                    settle_d = settle_q + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    if (skip_q != 3'd0) begin
                        skip_d = skip_q - 3'd1;
                    end else if (byte_q == SC_E1) begin
                        skip_d = SKIP_PAUSE;
                    end else if (byte_q == SC_E0) begin
                        ext_p_d = 1'b1;
                    end else if (byte_q == SC_F0) begin
                        brk_p_d = 1'b1;
                    end else begin
                        ev_d.code  = byte_q;
                        ev_d.ext   = ext_p_q;
                        ev_d.brk   = brk_p_q;
                        ev_d.rpt   = is_rpt;
                        ev_d.ascii = ascii_w;
                        ext_p_d    = 1'b0;
                        brk_p_d    = 1'b0;

                        // Modifier keys are tracked per side so releasing one
                        // Shift/Ctrl does not drop the state of the other.
                        if (byte_q == SC_LSHIFT) lshift_d = is_make;
                        if (byte_q == SC_RSHIFT) rshift_d = is_make;
                        if (byte_q == SC_CTRL) begin
                            if (ext_p_q) rctrl_d = is_make;
                            else         lctrl_d = is_make;
                        end

                        if (is_make && !is_rpt) begin
                            if (byte_q == SC_CAPS) caps_d = !caps_q;
                            last_key_d  = byte_q;
                            key_count_d = key_count_q + 8'd1;
                        end
                        if (!is_make && (byte_q == last_key_q)) begin
                            last_key_d = 8'h00;
                        end

                        ev_valid_d = 1'b1;
                        state_d    = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                // No pop here: a stalled consumer backs up into the FIFO.
                if (ev_ready) begin
                    ev_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Bytes were dropped upstream, so any partial prefix is meaningless.
        if (overflow) begin
            lost_d  = 1'b1;
            ext_p_d = 1'b0;
            brk_p_d = 1'b0;
            skip_d  = 3'd0;
        end

        shift_d = lshift_d | rshift_d;
        ctrl_d  = lctrl_d | rctrl_d;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            byte_q       <= 8'h00;
            ext_p_q      <= 1'b0;
            brk_p_q      <= 1'b0;
            skip_q       <= 3'd0;
            last_key_q   <= 8'h00;
            nextdata_n_q <= 1'b1;
            ev_valid_q   <= 1'b0;
            ev_q         <= '0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            shift_q      <= 1'b0;
            ctrl_q       <= 1'b0;
            caps_q       <= 1'b0;
            key_count_q  <= 8'h00;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            byte_q       <= byte_d;
            ext_p_q      <= ext_p_d;
            brk_p_q      <= brk_p_d;
            skip_q       <= skip_d;
            last_key_q   <= last_key_d;
            nextdata_n_q <= nextdata_n_d;
            ev_valid_q   <= ev_valid_d;
            ev_q         <= ev_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            lctrl_q      <= lctrl_d;
            rctrl_q      <= rctrl_d;
            shift_q      <= shift_d;
            ctrl_q       <= ctrl_d;
            caps_q       <= caps_d;
            key_count_q  <= key_count_d;
            lost_q       <= lost_d;
        end
    end

    assign nextdata_n = nextdata_n_q;
    assign ev_valid   = ev_valid_q;
    assign ev_code    = ev_q.code;
    assign ev_ext     = ev_q.ext;
    assign ev_break   = ev_q.brk;
    assign ev_repeat  = ev_q.rpt;
    assign ev_ascii   = ev_q.ascii;
    assign shift      = shift_q;
    assign ctrl       = ctrl_q;
    assign caps       = caps_q;
    assign key_count  = key_count_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder with a small receiver FIFO model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;
    logic [7:0] ev_ascii;
    logic       shift;
    logic       ctrl;
    logic       caps;
    logic [7:0] key_count;
    logic       lost;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Receiver FIFO: bench writes, pop on the edge that ends the low pulse.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    assign ready = (wr_ptr != rd_ptr);
    assign data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (!nextdata_n && ready) rd_ptr <= rd_ptr + 8'd1;
    end

    ps2_key_decoder #(.SETTLE_CYC(2)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_repeat  (ev_repeat),
        .ev_ascii   (ev_ascii),
        .shift      (shift),
        .ctrl       (ctrl),
        .caps       (caps),
        .key_count  (key_count),
        .lost       (lost)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!ev_valid && i < 60);
        check_eq({tag, " ev_valid"}, ev_valid, 1);
    endtask

    task automatic accept();
        ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
    endtask

    // Waits for an event and checks its payload; the caller accepts it.
    task automatic expect_event(input string tag, input logic [7:0] code, input logic ext,
                                input logic brk, input logic rpt, input logic [7:0] ascii);
        wait_valid(tag);
        check_eq({tag, " code"},   ev_code,   code);
        check_eq({tag, " ext"},    ev_ext,    ext);
        check_eq({tag, " break"},  ev_break,  brk);
        check_eq({tag, " repeat"}, ev_repeat, rpt);
        check_eq({tag, " ascii"},  ev_ascii,  ascii);
    endtask

    initial begin
        int p_cnt;
        int acc;
        int t1;
        int t2;

        clrn     = 1'b0;
        overflow = 1'b0;
        ev_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst nextdata_n", nextdata_n, 1);
        check_eq("rst ev_valid",   ev_valid,   0);
        check_eq("rst key_count",  key_count,  0);
        check_eq("rst shift",      shift,      0);
        check_eq("rst ctrl",       ctrl,       0);
        check_eq("rst caps",       caps,       0);
        check_eq("rst lost",       lost,       0);
        clrn = 1'b1;
        @(negedge clk);

        // a press / release
        push(8'h1C); push(8'hF0); push(8'h1C);
        expect_event("a_make", 8'h1C, 0, 0, 0, 8'h61);
        check_eq("a_make kc", key_count, 1);
        accept();
        expect_event("a_brk", 8'h1C, 0, 1, 0, 8'h61);
        check_eq("a_brk kc", key_count, 1);
        accept();

        // shifted letter
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        expect_event("sh_make", 8'h12, 0, 0, 0, 8'h00);
        check_eq("sh_make shift", shift, 1);
        accept();
        expect_event("A_make", 8'h1C, 0, 0, 0, 8'h41);
        accept();
        expect_event("A_brk", 8'h1C, 0, 1, 0, 8'h41);
        accept();
        expect_event("sh_brk", 8'h12, 0, 1, 0, 8'h00);
        check_eq("sh_brk shift", shift, 0);
        check_eq("sh_brk kc", key_count, 3);
        accept();

        // caps lock with typematic repeat, then shift cancelling caps
        push(8'h58); push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
        push(8'hF0); push(8'h1C); push(8'h12); push(8'h1C); push(8'hF0);
        push(8'h1C); push(8'hF0); push(8'h12);
        expect_event("caps1", 8'h58, 0, 0, 0, 8'h00);
        check_eq("caps1 caps", caps, 1);
        accept();
        expect_event("caps2", 8'h58, 0, 0, 1, 8'h00);
        check_eq("caps2 caps", caps, 1);
        accept();
        expect_event("caps_brk", 8'h58, 0, 1, 0, 8'h00);
        accept();
        expect_event("capsA", 8'h1C, 0, 0, 0, 8'h41);
        accept();
        expect_event("capsA_brk", 8'h1C, 0, 1, 0, 8'h41);
        accept();
        expect_event("caps_sh", 8'h12, 0, 0, 0, 8'h00);
        accept();
        expect_event("caps_sh_a", 8'h1C, 0, 0, 0, 8'h61);
        accept();
        expect_event("caps_sh_a_brk", 8'h1C, 0, 1, 0, 8'h61);
        accept();
        expect_event("caps_sh_brk", 8'h12, 0, 1, 0, 8'h00);
        check_eq("caps kc", key_count, 7);
        accept();

        // extended key make / break
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        expect_event("ext_make", 8'h75, 1, 0, 0, 8'h00);
        accept();
        expect_event("ext_brk", 8'h75, 1, 1, 0, 8'h00);
        accept();

        // Pause sequence is swallowed; space follows
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77); push(8'h29);
        expect_event("pause_space", 8'h29, 0, 0, 0, 8'h20);
        check_eq("pause ctrl", ctrl, 0);
        accept();

        // backpressure: one pop, then the event is held
        push(8'h1C); push(8'h32); push(8'h21);
        p_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!nextdata_n) p_cnt++;
        end
        check_eq("bp pulses", p_cnt, 1);
        check_eq("bp ev_valid", ev_valid, 1);
        check_eq("bp ev_code", ev_code, 8'h1C);

        ev_ready = 1'b1;
        p_cnt = 0; acc = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (ev_valid) acc++;
            if (!nextdata_n) begin
                p_cnt++;
                if (p_cnt == 1) t1 = i;
                else            t2 = i;
            end
            @(negedge clk);
        end
        ev_ready = 1'b0;
        check_eq("resume pulses", p_cnt, 2);
        check_eq("resume spacing>=4", (t2 - t1) >= 4, 1);
        check_eq("resume accepted", acc, 3);

        // asynchronous reset while an event is pending
        push(8'h29);
        wait_valid("rst_emit");
        clrn = 1'b0;
        #1;
        check_eq("rst_emit ev_valid",   ev_valid,   0);
        check_eq("rst_emit nextdata_n", nextdata_n, 1);
        check_eq("rst_emit key_count",  key_count,  0);
        check_eq("rst_emit caps",       caps,       0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        // key_count wraps after 256 distinct presses
        for (int i = 0; i < 255; i++) begin
            push((i % 2) ? 8'h1C : 8'h29);
            wait_valid("wrap");
            accept();
        end
        check_eq("wrap kc255", key_count, 255);
        push(8'h1C);
        wait_valid("wrap_last");
        check_eq("wrap kc0", key_count, 0);
        accept();

        // overflow discards a pending E0 and sets lost
        check_eq("ovf lost before", lost, 0);
        push(8'hE0);
        repeat (10) @(negedge clk);
        check_eq("ovf prefix no event", ev_valid, 0);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        check_eq("ovf lost", lost, 1);
        push(8'h75);
        expect_event("ovf_key", 8'h75, 0, 0, 0, 8'h00);
        accept();
        repeat (3) @(negedge clk);
        check_eq("ovf lost sticky", lost, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
